// File: rtl/blood_pkg.sv
// Shared parameters, FSM state encoding and colour type for the blood-splatter
// sprite reader.
package blood_pkg;

    localparam int SPR_DIM         = 64;
    localparam int ADDR_W          = 6;
    localparam int COLOR_W         = 12;
    localparam int NUM_FRAMES      = 16;
    localparam int FRAME_W         = 4;
    localparam int TICKS_PER_FRAME = 4;
    localparam int TICK_W          = 2;
    localparam int POS_W           = 10;

    localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [COLOR_W-1:0] rgb444_t;

    function automatic logic is_opaque(input rgb444_t color);
        return (color != TRANSPARENT);
    endfunction

endpackage

// File: rtl/blood_anim_seq.sv
// Animation sequencer: arms on hit, steps frames on vertical-blank ticks and
// handles retrigger through a pending shadow position.
module blood_anim_seq
    import blood_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hit,
    input  logic [POS_W-1:0]   hit_x,
    input  logic [POS_W-1:0]   hit_y,
    input  logic               v_tick,
    output logic [POS_W-1:0]   pos_x,
    output logic [POS_W-1:0]   pos_y,
    output logic               playing,
    output logic [FRAME_W-1:0] rom_frame,
    output logic               busy,
    output logic               done
);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

    state_t             state_r, state_s;
    logic [FRAME_W-1:0] frame_r, frame_s;
    logic [TICK_W-1:0]  tick_r, tick_s;
    logic [POS_W-1:0]   pos_x_r, pos_x_s, pos_y_r, pos_y_s;
    logic [POS_W-1:0]   shadow_x_r, shadow_x_s, shadow_y_r, shadow_y_s;
    logic               pend_r, pend_s;
    logic               busy_r, done_r;

    // Next-state logic: frame/tick/position only move on v_tick once playing
    always_comb begin
        state_s    = state_r;
        frame_s    = frame_r;
        tick_s     = tick_r;
        pos_x_s    = pos_x_r;
        pos_y_s    = pos_y_r;
        shadow_x_s = shadow_x_r;
        shadow_y_s = shadow_y_r;
        pend_s     = pend_r;
        case (state_r)
            IDLE, DONE: begin
                frame_s = {FRAME_W{1'b0}};
                tick_s  = {TICK_W{1'b0}};
                pend_s  = 1'b0;
                if (hit) begin
                    pos_x_s = hit_x;
                    pos_y_s = hit_y;
                    state_s = ARMED;
                end else begin
                    state_s = IDLE;
                end
            end
            ARMED: begin
                if (hit) begin
                    pos_x_s = hit_x;
                    pos_y_s = hit_y;
                end else begin
                    pos_x_s = pos_x_r;
                end
                if (v_tick) begin
                    state_s = PLAY;
                    frame_s = {FRAME_W{1'b0}};
                    tick_s  = {TICK_W{1'b0}};
                end else begin
                    state_s = ARMED;
                end
            end
            PLAY: begin
                if (v_tick) begin
                    // A pending or coincident retrigger beats the normal advance
                    if (pend_r || hit) begin
                        frame_s = {FRAME_W{1'b0}};
                        tick_s  = {TICK_W{1'b0}};
                        pend_s  = 1'b0;
                        pos_x_s = hit ? hit_x : shadow_x_r;
                        pos_y_s = hit ? hit_y : shadow_y_r;
                    end else if (tick_r == TICK_LAST) begin
                        tick_s = {TICK_W{1'b0}};
                        if (frame_r == FRAME_LAST) begin
                            state_s = DONE;
                        end else begin
                            frame_s = frame_r + 4'd1;
                        end
                    end else begin
                        tick_s = tick_r + 2'd1;
                    end
                end else if (hit) begin
                    pend_s     = 1'b1;
                    shadow_x_s = hit_x;
                    shadow_y_s = hit_y;
                end else begin
                    pend_s = pend_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            frame_r    <= {FRAME_W{1'b0}};
            tick_r     <= {TICK_W{1'b0}};
            pos_x_r    <= {POS_W{1'b0}};
            pos_y_r    <= {POS_W{1'b0}};
            shadow_x_r <= {POS_W{1'b0}};
            shadow_y_r <= {POS_W{1'b0}};
            pend_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            frame_r    <= frame_s;
            tick_r     <= tick_s;
            pos_x_r    <= pos_x_s;
            pos_y_r    <= pos_y_s;
            shadow_x_r <= shadow_x_s;
            shadow_y_r <= shadow_y_s;
            pend_r     <= pend_s;
            busy_r     <= (state_s != IDLE);
            done_r     <= (state_s == DONE);
        end
    end

    assign pos_x     = pos_x_r;
    assign pos_y     = pos_y_r;
    assign playing   = (state_r == PLAY);
    assign rom_frame = frame_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: rtl/blood_sprite_reader.sv
// Blood-splatter ROM client: region test and address generation from the pixel
// position, plus a 2-cycle output pipeline that hides the ROM read latency.
module blood_sprite_reader
    import blood_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hit,
    input  logic [POS_W-1:0]   hit_x,
    input  logic [POS_W-1:0]   hit_y,
    input  logic [POS_W-1:0]   x,
    input  logic [POS_W-1:0]   y,
    input  logic               video_on,
    input  logic               v_tick,
    output logic [ADDR_W-1:0]  rom_row,
    output logic [ADDR_W-1:0]  rom_col,
    output logic [FRAME_W-1:0] rom_frame,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               pix_valid,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               done
);

    localparam logic [POS_W:0] SPR_LIM = (POS_W + 1)'(SPR_DIM);

    logic [POS_W-1:0] pos_x_s, pos_y_s;
    logic             playing_s;
    logic [POS_W:0]   dx_s, dy_s;
    logic             in_spr_s, pix_valid_s;
    logic             in_spr_d_r, pix_valid_r;
    rgb444_t          pix_color_r;

    blood_anim_seq u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit       (hit),
        .hit_x     (hit_x),
        .hit_y     (hit_y),
        .v_tick    (v_tick),
        .pos_x     (pos_x_s),
        .pos_y     (pos_y_s),
        .playing   (playing_s),
        .rom_frame (rom_frame),
        .busy      (busy),
        .done      (done)
    );

    // Extra bit keeps left/above-of-sprite differences from aliasing into range
    assign dx_s = {1'b0, x} - {1'b0, pos_x_s};
    assign dy_s = {1'b0, y} - {1'b0, pos_y_s};

    assign in_spr_s = video_on && playing_s
                   && (x >= pos_x_s) && (y >= pos_y_s)
                   && (dx_s < SPR_LIM) && (dy_s < SPR_LIM);

    assign rom_col = dx_s[ADDR_W-1:0];
    assign rom_row = dy_s[ADDR_W-1:0];

    assign pix_valid_s = in_spr_d_r && is_opaque(rom_data);

    // Region flag aligned to ROM data, then the keyed output pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_spr_d_r  <= 1'b0;
            pix_valid_r <= 1'b0;
            pix_color_r <= {COLOR_W{1'b0}};
        end else begin
            in_spr_d_r  <= in_spr_s;
            pix_valid_r <= pix_valid_s;
            pix_color_r <= pix_valid_s ? rom_data : {COLOR_W{1'b0}};
        end
    end

    assign pix_valid = pix_valid_r;
    assign pix_color = pix_color_r;

endmodule

// File: tb/tb_blood_sprite_reader.sv
// Directed self-checking bench for blood_sprite_reader with a registered-address
// ROM model (single-dot image or an always-opaque coordinate pattern).
module tb_blood_sprite_reader;

    logic        clk, rst_n, hit, video_on, v_tick;
    logic [9:0]  hit_x, hit_y, x, y;
    logic [5:0]  rom_row, rom_col;
    logic [3:0]  rom_frame;
    logic [11:0] rom_data, pix_color;
    logic        pix_valid, busy, done;
    logic        rom_mode;
    int          tests, fails, done_cnt;

    blood_sprite_reader dut (
        .clk(clk), .rst_n(rst_n), .hit(hit), .hit_x(hit_x), .hit_y(hit_y),
        .x(x), .y(y), .video_on(video_on), .v_tick(v_tick),
        .rom_row(rom_row), .rom_col(rom_col), .rom_frame(rom_frame),
        .rom_data(rom_data), .pix_valid(pix_valid), .pix_color(pix_color),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM model: mode 0 = single red dot at (5,7); mode 1 = opaque {row,col,F}
    always @(posedge clk) begin
        if (rom_mode == 1'b0)
            rom_data <= (rom_row == 6'd5 && rom_col == 6'd7) ? 12'hE00 : 12'h000;
        else
            rom_data <= {rom_row[3:0], rom_col[3:0], 4'hF};
    end

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic do_hit(input logic [9:0] hx, input logic [9:0] hy);
        @(negedge clk); hit = 1'b1; hit_x = hx; hit_y = hy;
        @(negedge clk); hit = 1'b0;
    endtask

    task automatic vticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); v_tick = 1'b1;
            @(negedge clk); v_tick = 1'b0;
        end
    endtask

    task automatic probe(input logic [9:0] px, input logic [9:0] py, input logic vo,
                         output logic pv, output logic [11:0] pc);
        @(negedge clk); x = px; y = py; video_on = vo;
        @(negedge clk); video_on = 1'b0;
        @(negedge clk); pv = pix_valid; pc = pix_color;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        tests++;
        if ({pix_valid, pix_color, rom_frame, busy, done} !== 19'd0) begin
            fails++;
            $display("FAIL reset_outputs: got pv=%b pc=%h fr=%0d busy=%b done=%b, want all 0",
                     pix_valid, pix_color, rom_frame, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_start();
        logic pv; logic [11:0] pc;
        rom_mode = 1'b1;
        do_hit(10'd100, 10'd50);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL armed_busy: got %b want 1", busy); end
        probe(10'd100, 10'd50, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b0) begin fails++; $display("FAIL armed_no_draw: got pv=%b want 0", pv); end
        vticks(1);
        tests++;
        if (rom_frame !== 4'd0) begin fails++; $display("FAIL play_frame0: got %0d want 0", rom_frame); end
        @(negedge clk); x = 10'd100; y = 10'd50; #1;
        tests++;
        if ({rom_row, rom_col} !== 12'd0) begin
            fails++; $display("FAIL addr_origin: got row=%0d col=%0d want 0/0", rom_row, rom_col);
        end
        x = 10'd163; y = 10'd113; #1;
        tests++;
        if (rom_row !== 6'd63 || rom_col !== 6'd63) begin
            fails++; $display("FAIL addr_corner: got row=%0d col=%0d want 63/63", rom_row, rom_col);
        end
        probe(10'd163, 10'd113, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b1 || pc !== 12'hFFF) begin
            fails++; $display("FAIL pix_corner: got pv=%b pc=%h want 1/fff", pv, pc);
        end
        probe(10'd164, 10'd50, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b0 || pc !== 12'h000) begin
            fails++; $display("FAIL pix_right_edge: got pv=%b pc=%h want 0/000", pv, pc);
        end
        probe(10'd99, 10'd50, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b0) begin fails++; $display("FAIL pix_left_of: got pv=%b want 0", pv); end
        probe(10'd100, 10'd49, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b0) begin fails++; $display("FAIL pix_above: got pv=%b want 0", pv); end
        probe(10'd100, 10'd50, 1'b0, pv, pc);
        tests++;
        if (pv !== 1'b0) begin fails++; $display("FAIL pix_video_off: got pv=%b want 0", pv); end
    endtask

    task automatic test_rom_dot();
        logic pv; logic [11:0] pc;
        rom_mode = 1'b0;
        probe(10'd107, 10'd55, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b1 || pc !== 12'hE00) begin
            fails++; $display("FAIL dot_hit: got pv=%b pc=%h want 1/e00", pv, pc);
        end
        probe(10'd108, 10'd55, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b0 || pc !== 12'h000) begin
            fails++; $display("FAIL dot_transparent_x: got pv=%b pc=%h want 0/000", pv, pc);
        end
        probe(10'd107, 10'd56, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b0 || pc !== 12'h000) begin
            fails++; $display("FAIL dot_transparent_y: got pv=%b pc=%h want 0/000", pv, pc);
        end
        rom_mode = 1'b1;
    endtask

    task automatic test_animation();
        int start_done;
        start_done = done_cnt;
        for (int f = 0; f < 16; f++) begin
            tests++;
            if (rom_frame !== f[3:0]) begin
                fails++; $display("FAIL anim_frame: got %0d want %0d", rom_frame, f);
            end
            if (f < 15) vticks(4);
        end
        vticks(3);
        @(negedge clk); v_tick = 1'b1;
        @(negedge clk); v_tick = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL done_pulse: got done=%b busy=%b want 1/1", done, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || rom_frame !== 4'd0) begin
            fails++; $display("FAIL after_done: got done=%b busy=%b fr=%0d want 0/0/0", done, busy, rom_frame);
        end
        tests++;
        if (done_cnt - start_done !== 1) begin
            fails++; $display("FAIL done_count: got %0d want 1", done_cnt - start_done);
        end
    endtask

    task automatic test_retrigger();
        logic pv; logic [11:0] pc;
        int start_done;
        do_hit(10'd100, 10'd50);
        vticks(1);
        vticks(36);
        start_done = done_cnt;
        do_hit(10'd300, 10'd200);
        tests++;
        if (rom_frame !== 4'd9) begin fails++; $display("FAIL retrig_hold: got %0d want 9", rom_frame); end
        probe(10'd100, 10'd50, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b1) begin fails++; $display("FAIL retrig_old_pos: got pv=%b want 1", pv); end
        vticks(1);
        tests++;
        if (rom_frame !== 4'd0) begin fails++; $display("FAIL retrig_frame: got %0d want 0", rom_frame); end
        probe(10'd300, 10'd200, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b1 || pc !== 12'h00F) begin
            fails++; $display("FAIL retrig_new_pos: got pv=%b pc=%h want 1/00f", pv, pc);
        end
        probe(10'd100, 10'd50, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b0) begin fails++; $display("FAIL retrig_old_gone: got pv=%b want 0", pv); end
        // Walk to the last tick of the final frame and retrigger on the ending v_tick
        vticks(63);
        tests++;
        if (rom_frame !== 4'd15) begin fails++; $display("FAIL final_frame: got %0d want 15", rom_frame); end
        @(negedge clk); v_tick = 1'b1; hit = 1'b1; hit_x = 10'd10; hit_y = 10'd10;
        @(negedge clk); v_tick = 1'b0; hit = 1'b0;
        tests++;
        if (rom_frame !== 4'd0 || busy !== 1'b1) begin
            fails++; $display("FAIL final_restart: got fr=%0d busy=%b want 0/1", rom_frame, busy);
        end
        probe(10'd10, 10'd10, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b1 || pc !== 12'h00F) begin
            fails++; $display("FAIL final_new_pos: got pv=%b pc=%h want 1/00f", pv, pc);
        end
        tests++;
        if (done_cnt !== start_done) begin
            fails++; $display("FAIL retrig_no_done: got %0d pulses want 0", done_cnt - start_done);
        end
    endtask

    task automatic test_clip();
        logic pv; logic [11:0] pc;
        do_hit(10'd620, 10'd100);
        vticks(1);
        probe(10'd620, 10'd100, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b1 || pc !== 12'h00F) begin
            fails++; $display("FAIL clip_first: got pv=%b pc=%h want 1/00f", pv, pc);
        end
        probe(10'd639, 10'd100, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b1 || pc !== 12'h03F) begin
            fails++; $display("FAIL clip_last: got pv=%b pc=%h want 1/03f", pv, pc);
        end
        probe(10'd0, 10'd100, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b0) begin fails++; $display("FAIL clip_no_wrap0: got pv=%b want 0", pv); end
        probe(10'd43, 10'd101, 1'b1, pv, pc);
        tests++;
        if (pv !== 1'b0) begin fails++; $display("FAIL clip_no_wrap43: got pv=%b want 0", pv); end
    endtask

    task automatic test_async_reset();
        logic pv; logic [11:0] pc;
        vticks(28);
        tests++;
        if (rom_frame !== 4'd7) begin fails++; $display("FAIL pre_reset_frame: got %0d want 7", rom_frame); end
        @(negedge clk); x = 10'd625; y = 10'd100; video_on = 1'b1;
        @(negedge clk); @(negedge clk);
        tests++;
        if (pix_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_pix: got %b want 1", pix_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({pix_valid, pix_color, rom_frame, busy, done} !== 19'd0) begin
            fails++;
            $display("FAIL async_reset: got pv=%b pc=%h fr=%0d busy=%b done=%b, want all 0",
                     pix_valid, pix_color, rom_frame, busy, done);
        end
        @(negedge clk); rst_n = 1'b1; video_on = 1'b0;
        vticks(2);
        probe(10'd625, 10'd100, 1'b1, pv, pc);
        tests++;
        if (busy !== 1'b0 || pv !== 1'b0) begin
            fails++; $display("FAIL post_reset_idle: got busy=%b pv=%b want 0/0", busy, pv);
        end
        do_hit(10'd620, 10'd100);
        vticks(1);
        probe(10'd625, 10'd100, 1'b1, pv, pc);
        tests++;
        if (busy !== 1'b1 || pv !== 1'b1 || pc !== 12'h05F) begin
            fails++; $display("FAIL post_reset_restart: got busy=%b pv=%b pc=%h want 1/1/05f", busy, pv, pc);
        end
    endtask

    initial begin
        tests = 0; fails = 0; done_cnt = 0;
        rst_n = 1'b0; hit = 1'b0; hit_x = 10'd0; hit_y = 10'd0;
        x = 10'd0; y = 10'd0; video_on = 1'b0; v_tick = 1'b0; rom_mode = 1'b1;
        test_reset();
        test_start();
        test_rom_dot();
        test_animation();
        test_retrigger();
        test_clip();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
